// File: rtl/vqueue_pkg.sv
// Shared definitions for the vertex queue family (single- and dual-clock).
// Holds the default geometry constants, flag bundle type and the
// threshold-compare helper used to decode occupancy flags.
package vqueue_pkg;

  localparam int ADDR_WIDTH_DFLT = 5;
  localparam int DEPTH = 1 << ADDR_WIDTH_DFLT;
  localparam int PTR_W = ADDR_WIDTH_DFLT + 1;

  // Comparison flavour for occupancy thresholds.
  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_GE = 2'd1,
    CMP_EQ = 2'd2
  } cmp_e;

  // Registered occupancy flags, all decoded from the same next-state count.
  typedef struct packed {
    logic full;
    logic almost_full;
    logic almost_empty;
    logic almost_empty2;
  } flags_t;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic int unsigned ptr_w_of(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

  // Occupancy threshold compare shared by every queue flavour.
  function automatic logic thr_cmp(input int unsigned value,
                                   input int unsigned thr,
                                   input cmp_e op);
    logic res;
    res = 1'b0;
    unique case (op)
      CMP_LT:  res = (value < thr);
      CMP_GE:  res = (value >= thr);
      CMP_EQ:  res = (value == thr);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/vqueue_sc_if.sv
// Producer/consumer bus of the single-clock vertex queue.
// master: the side driving writes/pops; slave: the queue itself.
interface vqueue_sc_if
  import vqueue_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  localparam int CNT_W = int'(ptr_w_of(ADDR_WIDTH));

  logic                  WrEn;
  logic [DATA_WIDTH-1:0] Data;
  logic                  RdEn;
  logic [DATA_WIDTH-1:0] Q;
  logic                  Empty;
  logic                  Full;
  logic                  AlmostEmpty;
  logic                  AlmostEmpty2;
  logic                  AlmostFull;
  logic [CNT_W-1:0]      Count;
  logic                  ErrClear;
  logic                  Overflow;
  logic                  Underflow;

  modport master (
    output WrEn, Data, RdEn, ErrClear,
    input  Q, Empty, Full, AlmostEmpty, AlmostEmpty2, AlmostFull, Count,
           Overflow, Underflow
  );

  modport slave (
    input  WrEn, Data, RdEn, ErrClear,
    output Q, Empty, Full, AlmostEmpty, AlmostEmpty2, AlmostFull, Count,
           Overflow, Underflow
  );

endinterface

// File: rtl/vqueue_sc_mem.sv
// Simple dual-port single-clock RAM: one write port, one registered read
// port. No reset on the array or read register so it maps onto block RAM.
module vqueue_sc_mem
  import vqueue_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int MEM_DEPTH = int'(depth_of(ADDR_WIDTH));

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its word while rd_en is low.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/vqueue_sc.sv
// Single-clock FWFT vertex queue between command producer and rasteriser.
// Pointers are one bit wider than the address so all entries are usable.
// Read path: RAM registered read (prefetch stage) feeding the Q register,
// giving two-cycle write-to-Q latency and one pop per cycle with no bubble.
// Optional build macro: VQUEUE_ERR_FLAGS_EN enables sticky Overflow and
// Underflow flags; without it both are tied low and ErrClear is unused.
module vqueue_sc
  import vqueue_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 5,
  parameter int ALMOST_EMPTY       = 8,
  parameter int ALMOST_EMPTY2      = 16,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic        Clock,
  input  logic        ResetN,
  vqueue_sc_if.slave  bus
);

  localparam int unsigned QDEPTH = depth_of(ADDR_WIDTH);
  localparam int          QPTR_W = int'(ptr_w_of(ADDR_WIDTH));

  logic [QPTR_W-1:0]     wr_ptr, rd_ptr, fetch_ptr;
  logic [QPTR_W-1:0]     wr_ptr_next, rd_ptr_next, count_next;
  logic                  wr_acc, rd_acc, avail, move_pf, fetch_en;
  logic                  pf_valid, out_valid;
  logic [DATA_WIDTH-1:0] pf_data, q_reg;
  flags_t                flags_q, flags_next;

  // Full is the registered flag, so a pop in the same cycle cannot make
  // room for a write; pops are judged on the visible output word only.
  assign wr_acc = bus.WrEn & ~flags_q.full;
  assign rd_acc = bus.RdEn & out_valid;

  // A word exists in RAM that has not yet entered the read pipeline.
  assign avail    = (fetch_ptr != wr_ptr);
  // The prefetched word advances when the output slot is empty or popped.
  assign move_pf  = pf_valid & (~out_valid | rd_acc);
  // Fetch only when the prefetch slot is free after this edge.
  assign fetch_en = avail & (~pf_valid | move_pf);

  assign wr_ptr_next = wr_acc ? wr_ptr + QPTR_W'(1) : wr_ptr;
  assign rd_ptr_next = rd_acc ? rd_ptr + QPTR_W'(1) : rd_ptr;
  assign count_next  = wr_ptr_next - rd_ptr_next;

  // Decode occupancy flags from the next-state count so they line up with Count.
  always_comb begin
    flags_next               = '0;
    flags_next.full          = thr_cmp(32'(count_next), QDEPTH, CMP_EQ);
    flags_next.almost_full   = thr_cmp(32'(count_next),
                                       QDEPTH - 32'(ALMOST_FULL_MARGIN), CMP_GE);
    flags_next.almost_empty  = thr_cmp(32'(count_next), 32'(ALMOST_EMPTY), CMP_LT);
    flags_next.almost_empty2 = thr_cmp(32'(count_next), 32'(ALMOST_EMPTY2), CMP_LT);
  end

  // Pointers and registered flags.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fetch_ptr <= '0;
      flags_q   <= '{full: 1'b0, almost_full: 1'b0,
                     almost_empty: 1'b1, almost_empty2: 1'b1};
    end else begin
      wr_ptr  <= wr_ptr_next;
      rd_ptr  <= rd_ptr_next;
      flags_q <= flags_next;
      if (fetch_en) begin
        fetch_ptr <= fetch_ptr + QPTR_W'(1);
      end
    end
  end

  // Prefetch-valid and output register (Q / valid) pipeline.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      pf_valid  <= 1'b0;
      out_valid <= 1'b0;
      q_reg     <= '0;
    end else begin
      pf_valid <= fetch_en | (pf_valid & ~move_pf);
      if (move_pf) begin
        q_reg     <= pf_data;
        out_valid <= 1'b1;
      end else if (rd_acc) begin
        out_valid <= 1'b0;
      end
    end
  end

  vqueue_sc_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (Clock),
    .wr_en   (wr_acc & ResetN),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (bus.Data),
    .rd_en   (fetch_en),
    .rd_addr (fetch_ptr[ADDR_WIDTH-1:0]),
    .rd_data (pf_data)
  );

  assign bus.Q            = q_reg;
  assign bus.Empty        = ~out_valid;
  assign bus.Full         = flags_q.full;
  assign bus.AlmostFull   = flags_q.almost_full;
  assign bus.AlmostEmpty  = flags_q.almost_empty;
  assign bus.AlmostEmpty2 = flags_q.almost_empty2;
  assign bus.Count        = wr_ptr - rd_ptr;

`ifdef VQUEUE_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~bus.ErrClear) | (bus.WrEn & flags_q.full);
      unf_q <= (unf_q & ~bus.ErrClear) | (bus.RdEn & ~out_valid);
    end
  end

  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = bus.ErrClear;
  assign bus.Overflow     = 1'b0;
  assign bus.Underflow    = 1'b0;
`endif

endmodule
